// File: rtl/sdma_capture_buf.sv
// sdma_capture_buf: multi-channel ping-pong capture buffer between the
// synchronised ADC sample stream and the FSMC read side. One bank fills while
// the other is frozen for the MCU; banks swap on each delivered frame.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous reset, active-high
//   smp_valid_i    one-cycle sample strobe
//   smp_data_i     CH samples, channel c at [c*DW +: DW]
//   trig_i         trigger input (synchronous to clk_i)
//   trig_mode_i    00 free-run, 01 rising, 10 falling, 11 single-shot rising
//   decim_i        store every (decim_i+1)th accepted sample
//   arm_i          re-arm pulse, honoured only in HOLD
//   rd_lock_i      MCU read in progress; read bank must stay frozen
//   rd_en_i        read request
//   rd_ch_i        read channel
//   rd_addr_i      read sample index
//   rd_data_o      registered read data
//   rd_valid_o     rd_data_o valid, one cycle after rd_en_i
//   frame_ready_o  completed frame present in read bank
//   frame_cnt_o    frames delivered (wraps)
//   drop_cnt_o     frames discarded due to rd_lock_i (saturates)
//   state_o        00 ARMED, 01 FILL, 10 HOLD
module sdma_capture_buf #(
  parameter int unsigned CH    = 2,
  parameter int unsigned DW    = 12,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned CW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             smp_valid_i,
  input  logic [CH*DW-1:0] smp_data_i,
  input  logic             trig_i,
  input  logic [1:0]       trig_mode_i,
  input  logic [15:0]      decim_i,
  input  logic             arm_i,
  input  logic             rd_lock_i,
  input  logic             rd_en_i,
  input  logic [CW-1:0]    rd_ch_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [DW-1:0]    rd_data_o,
  output logic             rd_valid_o,
  output logic             frame_ready_o,
  output logic [15:0]      frame_cnt_o,
  output logic [15:0]      drop_cnt_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ARMED = 2'b00,
    FILL  = 2'b01,
    HOLD  = 2'b10
  } state_e;

  localparam int unsigned CNTW = 16;

  state_e          state_q, state_d;
  logic            wr_bank_q, wr_bank_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0] dcnt_q, dcnt_d;
  logic [CNTW-1:0] decim_l_q, decim_l_d;
  logic            frame_ready_q, frame_ready_d;
  logic [CNTW-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;
  logic            trig_q;
  // Low for the first cycle after reset so a level held through reset is not seen as an edge.
  logic            trig_vld_q;
  logic            rd_lock_q;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            rd_valid_q;

  logic            rise_c, fall_c, go_c, lock_fall_c, we_c;
  logic [DW-1:0]   ch_rd_c [CH];

  assign rise_c      = trig_vld_q & trig_i & ~trig_q;
  assign fall_c      = trig_vld_q & ~trig_i & trig_q;
  assign lock_fall_c = ~rd_lock_i & rd_lock_q;

  // Trigger qualification while ARMED.
  assign go_c = (trig_mode_i == 2'b00)
              | (trig_mode_i[0] & rise_c)
              | ((trig_mode_i == 2'b10) & fall_c);

  // Per-channel storage: two banks of DEPTH samples, asynchronous read port.
  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [DW-1:0] mem [2][DEPTH];

    always_ff @(posedge clk_i) begin
      if (we_c && !rst_i) begin
        mem[wr_bank_q][wr_ptr_q] <= smp_data_i[g*DW +: DW];
      end
    end

    assign ch_rd_c[g] = mem[~wr_bank_q][rd_addr_i];
  end

  // Next-state, write control and frame accounting.
  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    wr_ptr_d      = wr_ptr_q;
    dcnt_d        = dcnt_q;
    decim_l_d     = decim_l_q;
    frame_ready_d = frame_ready_q;
    frame_cnt_d   = frame_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    we_c          = 1'b0;

    // Reader released the bank; a completion below in the same cycle overrides this.
    if (lock_fall_c) begin
      frame_ready_d = 1'b0;
    end

    unique case (state_q)
      ARMED: begin
        if (go_c) begin
          state_d   = FILL;
          wr_ptr_d  = '0;
          dcnt_d    = '0;
          decim_l_d = decim_i;
        end
      end

      FILL: begin
        if (smp_valid_i) begin
          dcnt_d = (dcnt_q == decim_l_q) ? '0 : dcnt_q + CNTW'(1);
          if (dcnt_q == '0) begin
            we_c     = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (wr_ptr_q == AW'(DEPTH - 1)) begin
              wr_ptr_d = '0;
              if (!rd_lock_i) begin
                wr_bank_d     = ~wr_bank_q;
                frame_ready_d = 1'b1;
                frame_cnt_d   = frame_cnt_q + CNTW'(1);
              end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + CNTW'(1);
              end
              state_d = (trig_mode_i == 2'b11) ? HOLD : ARMED;
            end
          end
        end
      end

      HOLD: begin
        if (arm_i) begin
          state_d = ARMED;
        end
      end

      default: begin
        state_d = ARMED;
      end
    endcase
  end

  // Read data mux; nonexistent channels read as zero. Bank follows wr_bank_q at the request cycle.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      if (32'(rd_ch_i) < CH) begin
        rd_data_d = ch_rd_c[rd_ch_i];
      end else begin
        rd_data_d = '0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ARMED;
      wr_bank_q     <= 1'b0;
      wr_ptr_q      <= '0;
      dcnt_q        <= '0;
      decim_l_q     <= '0;
      frame_ready_q <= 1'b0;
      frame_cnt_q   <= '0;
      drop_cnt_q    <= '0;
      trig_q        <= 1'b0;
      trig_vld_q    <= 1'b0;
      rd_lock_q     <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      wr_ptr_q      <= wr_ptr_d;
      dcnt_q        <= dcnt_d;
      decim_l_q     <= decim_l_d;
      frame_ready_q <= frame_ready_d;
      frame_cnt_q   <= frame_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      trig_q        <= trig_i;
      trig_vld_q    <= 1'b1;
      rd_lock_q     <= rd_lock_i;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_en_i;
    end
  end

  assign rd_data_o     = rd_data_q;
  assign rd_valid_o    = rd_valid_q;
  assign frame_ready_o = frame_ready_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign drop_cnt_o    = drop_cnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_sdma_capture_buf.sv
// tb_sdma_capture_buf: self-checking bench for sdma_capture_buf (CH=2, DW=12, DEPTH=16).
// Read results are checked through an expected-value queue filled when a read is issued.
module tb_sdma_capture_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        smp_valid;
  logic [23:0] smp_data;
  logic        trig;
  logic [1:0]  trig_mode;
  logic [15:0] decim;
  logic        arm;
  logic        rd_lock;
  logic        rd_en;
  logic [0:0]  rd_ch;
  logic [3:0]  rd_addr;
  logic [11:0] rd_data;
  logic        rd_valid;
  logic        frame_ready;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q [$];
  logic [11:0] mon_exp;

  always #5 clk = ~clk;

  sdma_capture_buf #(.CH(2), .DW(12), .DEPTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .smp_valid_i(smp_valid), .smp_data_i(smp_data),
    .trig_i(trig), .trig_mode_i(trig_mode), .decim_i(decim), .arm_i(arm),
    .rd_lock_i(rd_lock), .rd_en_i(rd_en), .rd_ch_i(rd_ch), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .frame_ready_o(frame_ready),
    .frame_cnt_o(frame_cnt), .drop_cnt_o(drop_cnt), .state_o(state)
  );

  // Scoreboard: every rd_valid must match the oldest outstanding expected read value.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_valid_unexpected: rd_valid=1 rd_data=%0d, no read outstanding", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_data !== mon_exp) begin
          errors++;
          $display("FAIL rd_data: got %0d expected %0d", rd_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input logic [11:0] d0, input logic [11:0] d1);
    smp_valid = 1'b1;
    smp_data  = {d1, d0};
    @(negedge clk);
    smp_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read(input logic [0:0] ch, input logic [3:0] addr, input logic [11:0] e);
    exp_q.push_back(e);
    rd_en   = 1'b1;
    rd_ch   = ch;
    rd_addr = addr;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    trig_mode = 2'b00; decim = 16'd0; trig = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL reset_frame_ready: got %0d expected 0", frame_ready); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    checks++; if (rd_valid !== 1'b0 || rd_data !== 12'd0) begin errors++; $display("FAIL reset_rd: got valid=%0d data=%0d expected 0/0", rd_valid, rd_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_free_run();
    trig_mode = 2'b00; decim = 16'd0; trig = 1'b0;
    reset_dut();
    for (int i = 0; i < 16; i++) send(12'(2000 + i), 12'(i));
    checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL free_frame_ready: got %0d expected 1", frame_ready); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL free_frame_cnt: got %0d expected 1", frame_cnt); end
    do_read(1'b0, 4'd5, 12'd2005);
    do_read(1'b1, 4'd15, 12'd15);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL free_reads_outstanding: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_rising();
    trig_mode = 2'b01; decim = 16'd0; trig = 1'b1;
    reset_dut();
    for (int i = 0; i < 40; i++) send(12'(i), 12'd0);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL rise_held_state: got %0d expected 0", state); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rise_held_frame_cnt: got %0d expected 0", frame_cnt); end
    trig = 1'b0;
    @(negedge clk);
    trig = 1'b1;
    send(12'd999, 12'd999);  // same cycle as the trigger edge: must not be stored
    for (int i = 0; i < 16; i++) send(12'(100 + i), 12'(50 + i));
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rise_frame_cnt: got %0d expected 1", frame_cnt); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL rise_state_after: got %0d expected 0", state); end
    do_read(1'b0, 4'd0, 12'd100);
    do_read(1'b1, 4'd15, 12'd65);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rise_reads_outstanding: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_decim();
    trig_mode = 2'b00; decim = 16'd3; trig = 1'b0;
    reset_dut();
    for (int i = 0; i < 64; i++) begin
      if (i == 32) decim = 16'd0;  // must be ignored mid-frame
      send(12'(i), 12'd0);
    end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL decim_frame_cnt: got %0d expected 1", frame_cnt); end
    do_read(1'b0, 4'd0, 12'd0);
    do_read(1'b0, 4'd1, 12'd4);
    do_read(1'b0, 4'd7, 12'd28);
    do_read(1'b0, 4'd15, 12'd60);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL decim_reads_outstanding: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_lock_drop();
    trig_mode = 2'b00; decim = 16'd0; trig = 1'b0; rd_lock = 1'b0;
    reset_dut();
    for (int i = 0; i < 16; i++) send(12'(500 + i), 12'd0);
    idle(2);
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL lock_first_frame_cnt: got %0d expected 1", frame_cnt); end
    rd_lock = 1'b1;
    for (int i = 0; i < 16; i++) send(12'(700 + i), 12'd0);
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL lock_drop_cnt: got %0d expected 1", drop_cnt); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL lock_frame_cnt: got %0d expected 1", frame_cnt); end
    checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL lock_frame_ready_held: got %0d expected 1", frame_ready); end
    do_read(1'b0, 4'd3, 12'd503);
    rd_lock = 1'b0;
    @(negedge clk);
    checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL lock_release_frame_ready: got %0d expected 0", frame_ready); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL lock_reads_outstanding: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_single_shot();
    trig_mode = 2'b11; decim = 16'd0; trig = 1'b0; arm = 1'b0;
    reset_dut();
    idle(1);
    pulse_trig();
    for (int i = 0; i < 16; i++) send(12'(300 + i), 12'd0);
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL ss_frame_cnt: got %0d expected 1", frame_cnt); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL ss_hold_state: got %0d expected 2", state); end
    for (int k = 0; k < 3; k++) pulse_trig();
    for (int i = 0; i < 32; i++) send(12'(i), 12'd0);
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL ss_hold_frame_cnt: got %0d expected 1", frame_cnt); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL ss_hold_state2: got %0d expected 2", state); end
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL ss_arm_state: got %0d expected 0", state); end
    pulse_trig();
    for (int i = 0; i < 16; i++) send(12'(800 + i), 12'd0);
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL ss_rearm_frame_cnt: got %0d expected 2", frame_cnt); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL ss_rearm_state: got %0d expected 2", state); end
    do_read(1'b0, 4'd0, 12'd800);
    do_read(1'b0, 4'd9, 12'd809);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ss_reads_outstanding: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    trig_mode = 2'b00; decim = 16'd0; trig = 1'b0;
    reset_dut();
    do_read(1'b0, 4'd0, 12'd800);  // RAM survives reset; read bank is bank 1
    for (int i = 0; i < 7; i++) send(12'(900 + i), 12'd0);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (state !== 2'b00 || frame_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_state: got state=%0d ready=%0d expected 0/0", state, frame_ready); end
    checks++; if (frame_cnt !== 16'd0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset_counts: got %0d/%0d expected 0/0", frame_cnt, drop_cnt); end
    checks++; if (rd_data !== 12'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_rd: got data=%0d valid=%0d expected 0/0", rd_data, rd_valid); end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) send(12'(40 + i), 12'(60 + i));
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL mid_frame_cnt: got %0d expected 1", frame_cnt); end
    do_read(1'b0, 4'd0, 12'd40);
    do_read(1'b1, 4'd6, 12'd66);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_reads_outstanding: got %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; smp_valid = 1'b0; smp_data = '0; trig = 1'b0; trig_mode = 2'b00;
    decim = 16'd0; arm = 1'b0; rd_lock = 1'b0; rd_en = 1'b0; rd_ch = '0; rd_addr = '0;
    test_reset();
    test_free_run();
    test_rising();
    test_decim();
    test_lock_drop();
    test_single_shot();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
